// File: rtl/bram_addr_seq.sv
// PL-side port-B address sequencer for the PS/PL shared BRAM: walks a (base, length)
// window per job in read or write mode, optionally wrapping, with a latency-aligned read strobe.
module bram_addr_seq #(
    parameter int ADDR_W   = 16,
    parameter int WE_W     = 4,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic              wrap_en,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len_m1,
    input  logic              step_en,
    input  logic              stop,
    output logic [ADDR_W-1:0] pl_addr_logic,
    output logic              pl_en,
    output logic [WE_W-1:0]   pl_wr_en,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              wrap_pulse
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic                wrap_q, wrap_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                en_q, en_d;
    logic [WE_W-1:0]     we_q, we_d;
    logic                done_q, done_d;
    logic                wrap_pulse_q, wrap_pulse_d;
    logic [READ_LAT-1:0] vld_pipe_q, vld_pipe_d;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        wrap_d       = wrap_q;
        base_d       = base_q;
        len_d        = len_q;
        cur_addr_d   = cur_addr_q;
        beat_cnt_d   = beat_cnt_q;
        addr_d       = addr_q;
        en_d         = 1'b0;
        we_d         = '0;
        done_d       = 1'b0;
        wrap_pulse_d = 1'b0;

        // Read strobe tracks the registered beat, so it keeps draining after stop/done.
        vld_pipe_d[0] = en_q & ~we_q[0];
        for (int i = 1; i < READ_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d     = mode;
                    wrap_d     = wrap_en;
                    base_d     = base_addr;
                    len_d      = len_m1;
                    cur_addr_d = base_addr;
                    beat_cnt_d = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (step_en) begin
                    addr_d = cur_addr_q;
                    en_d   = 1'b1;
                    we_d   = {WE_W{mode_q}};
                    if (beat_cnt_q == len_q) begin
                        if (wrap_q) begin
                            cur_addr_d   = base_q;
                            beat_cnt_d   = '0;
                            wrap_pulse_d = 1'b1;
                        end else begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        cur_addr_d = cur_addr_q + 1'b1;
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            wrap_q       <= 1'b0;
            base_q       <= '0;
            len_q        <= '0;
            cur_addr_q   <= '0;
            beat_cnt_q   <= '0;
            addr_q       <= '0;
            en_q         <= 1'b0;
            we_q         <= '0;
            done_q       <= 1'b0;
            wrap_pulse_q <= 1'b0;
            vld_pipe_q   <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            wrap_q       <= wrap_d;
            base_q       <= base_d;
            len_q        <= len_d;
            cur_addr_q   <= cur_addr_d;
            beat_cnt_q   <= beat_cnt_d;
            addr_q       <= addr_d;
            en_q         <= en_d;
            we_q         <= we_d;
            done_q       <= done_d;
            wrap_pulse_q <= wrap_pulse_d;
            vld_pipe_q   <= vld_pipe_d;
        end
    end

    assign pl_addr_logic = addr_q;
    assign pl_en         = en_q;
    assign pl_wr_en      = we_q;
    assign rd_valid      = vld_pipe_q[READ_LAT-1];
    assign busy          = (state_q == RUN);
    assign done          = done_q;
    assign wrap_pulse    = wrap_pulse_q;

endmodule

// File: tb/tb_bram_addr_seq.sv
// Directed bench for bram_addr_seq: per-cycle expectations go through a scoreboard queue
// and are checked #1 after each rising edge; rd_valid expectation is a delay of expected read beats.
module tb_bram_addr_seq;

    localparam int ADDR_W   = 16;
    localparam int WE_W     = 4;
    localparam int READ_LAT = 1;

    typedef struct {
        logic              en;
        logic [WE_W-1:0]   we;
        logic [ADDR_W-1:0] addr;
        logic              rdv;
        logic              busy;
        logic              done;
        logic              wrap;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, mode, wrap_en, step_en, stop;
    logic [ADDR_W-1:0] base_addr, len_m1;
    logic [ADDR_W-1:0] pl_addr_logic;
    logic              pl_en;
    logic [WE_W-1:0]   pl_wr_en;
    logic              rd_valid, busy, done, wrap_pulse;

    int vectors     = 0;
    int miscompares = 0;

    exp_t                sb[$];
    logic [READ_LAT-1:0] rd_model = '0;
    logic                rd_in    = 1'b0;

    bram_addr_seq #(.ADDR_W(ADDR_W), .WE_W(WE_W), .READ_LAT(READ_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .wrap_en(wrap_en),
        .base_addr(base_addr), .len_m1(len_m1), .step_en(step_en), .stop(stop),
        .pl_addr_logic(pl_addr_logic), .pl_en(pl_en), .pl_wr_en(pl_wr_en),
        .rd_valid(rd_valid), .busy(busy), .done(done), .wrap_pulse(wrap_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic job(input logic m, input logic w, input logic [ADDR_W-1:0] b,
                       input logic [ADDR_W-1:0] l);
        start = 1'b1; mode = m; wrap_en = w; base_addr = b; len_m1 = l;
    endtask

    // One clock: apply step/stop, push expected outputs, then pop and compare after the edge.
    task automatic cyc(input string tag, input logic se, input logic sp,
                       input logic e_en, input logic e_wr, input logic [ADDR_W-1:0] e_addr,
                       input logic e_busy, input logic e_done, input logic e_wrap);
        exp_t e, o;
        step_en = se; stop = sp;
        rd_model = (rd_model << 1) | READ_LAT'(rd_in);
        e.en = e_en; e.we = {WE_W{e_wr}}; e.addr = e_addr; e.rdv = rd_model[READ_LAT-1];
        e.busy = e_busy; e.done = e_done; e.wrap = e_wrap;
        rd_in = e_en & ~e_wr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        chk({tag, ".pl_en"},    32'(pl_en),         32'(o.en));
        chk({tag, ".pl_wr_en"}, 32'(pl_wr_en),      32'(o.we));
        chk({tag, ".addr"},     32'(pl_addr_logic), 32'(o.addr));
        chk({tag, ".rd_valid"}, 32'(rd_valid),      32'(o.rdv));
        chk({tag, ".busy"},     32'(busy),          32'(o.busy));
        chk({tag, ".done"},     32'(done),          32'(o.done));
        chk({tag, ".wrap"},     32'(wrap_pulse),    32'(o.wrap));
        start = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".pl_en"},    32'(pl_en),         32'h0);
        chk({tag, ".pl_wr_en"}, 32'(pl_wr_en),      32'h0);
        chk({tag, ".addr"},     32'(pl_addr_logic), 32'h0);
        chk({tag, ".rd_valid"}, 32'(rd_valid),      32'h0);
        chk({tag, ".busy"},     32'(busy),          32'h0);
        chk({tag, ".done"},     32'(done),          32'h0);
        chk({tag, ".wrap"},     32'(wrap_pulse),    32'h0);
    endtask

    initial begin
        logic [ADDR_W-1:0] wa [10];
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; wrap_en = 1'b0; step_en = 1'b0; stop = 1'b0;
        base_addr = '0; len_m1 = '0;
        #2 chk_reset("por");
        #10 rst_n = 1'b1;

        // read job, step_en held high
        job(1'b0, 1'b0, 16'h0010, 16'd3);
        cyc("rd.start", 1, 0, 0, 0, 16'h0000, 1, 0, 0);
        cyc("rd.b0",    1, 0, 1, 0, 16'h0010, 1, 0, 0);
        cyc("rd.b1",    1, 0, 1, 0, 16'h0011, 1, 0, 0);
        cyc("rd.b2",    1, 0, 1, 0, 16'h0012, 1, 0, 0);
        cyc("rd.b3",    1, 0, 1, 0, 16'h0013, 0, 1, 0);
        cyc("rd.tail",  0, 0, 0, 0, 16'h0013, 0, 0, 0);
        cyc("rd.idle",  0, 0, 0, 0, 16'h0013, 0, 0, 0);

        // write job with step gaps
        job(1'b1, 1'b0, 16'h0100, 16'd2);
        cyc("wr.start", 0, 0, 0, 0, 16'h0013, 1, 0, 0);
        cyc("wr.b0",    1, 0, 1, 1, 16'h0100, 1, 0, 0);
        cyc("wr.gap0",  0, 0, 0, 0, 16'h0100, 1, 0, 0);
        cyc("wr.b1",    1, 0, 1, 1, 16'h0101, 1, 0, 0);
        cyc("wr.gap1",  0, 0, 0, 0, 16'h0101, 1, 0, 0);
        cyc("wr.b2",    1, 0, 1, 1, 16'h0102, 0, 1, 0);
        cyc("wr.idle",  0, 0, 0, 0, 16'h0102, 0, 0, 0);

        // top-of-memory window in continuous mode, ended by stop
        wa = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'hFFFE,
               16'hFFFF, 16'h0000, 16'h0001, 16'hFFFE, 16'hFFFF};
        job(1'b0, 1'b1, 16'hFFFE, 16'd3);
        cyc("wp.start", 0, 0, 0, 0, 16'h0102, 1, 0, 0);
        for (int i = 0; i < 10; i++)
            cyc($sformatf("wp.b%0d", i), 1, 0, 1, 0, wa[i], 1, 0, (i == 3) || (i == 7));
        cyc("wp.stop",  0, 1, 0, 0, 16'hFFFF, 0, 0, 0);
        cyc("wp.idle",  0, 0, 0, 0, 16'hFFFF, 0, 0, 0);

        // abort after three beats; then stop wins over step_en
        job(1'b0, 1'b0, 16'h0020, 16'd7);
        cyc("ab.start", 0, 0, 0, 0, 16'hFFFF, 1, 0, 0);
        cyc("ab.b0",    1, 0, 1, 0, 16'h0020, 1, 0, 0);
        cyc("ab.b1",    1, 0, 1, 0, 16'h0021, 1, 0, 0);
        cyc("ab.b2",    1, 0, 1, 0, 16'h0022, 1, 0, 0);
        cyc("ab.stop",  0, 1, 0, 0, 16'h0022, 0, 0, 0);
        cyc("ab.idle",  1, 1, 0, 0, 16'h0022, 0, 0, 0);
        job(1'b0, 1'b0, 16'h0030, 16'd7);
        cyc("ss.start", 0, 0, 0, 0, 16'h0022, 1, 0, 0);
        cyc("ss.both",  1, 1, 0, 0, 16'h0022, 0, 0, 0);

        // start ignored in RUN; start in the done cycle gives back-to-back jobs
        job(1'b0, 1'b0, 16'h0040, 16'd1);
        cyc("bb.start", 0, 0, 0, 0, 16'h0022, 1, 0, 0);
        job(1'b1, 1'b0, 16'h0080, 16'd0);
        cyc("bb.b0",    1, 0, 1, 0, 16'h0040, 1, 0, 0);
        cyc("bb.b1",    1, 0, 1, 0, 16'h0041, 0, 1, 0);
        job(1'b0, 1'b0, 16'h0200, 16'd0);
        cyc("bb.start2", 1, 0, 0, 0, 16'h0041, 1, 0, 0);
        cyc("bb.c0",    1, 0, 1, 0, 16'h0200, 0, 1, 0);
        cyc("bb.idle",  0, 0, 0, 0, 16'h0200, 0, 0, 0);

        // asynchronous reset in the middle of a job
        job(1'b0, 1'b0, 16'h0050, 16'd5);
        cyc("rs.start", 0, 0, 0, 0, 16'h0200, 1, 0, 0);
        cyc("rs.b0",    1, 0, 1, 0, 16'h0050, 1, 0, 0);
        cyc("rs.b1",    1, 0, 1, 0, 16'h0051, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk_reset("rs.async");
        rd_model = '0; rd_in = 1'b0;
        #2 rst_n = 1'b1;
        cyc("rs.post",  1, 0, 0, 0, 16'h0000, 0, 0, 0);
        job(1'b0, 1'b0, 16'h0060, 16'd0);
        cyc("rs.start2", 0, 0, 0, 0, 16'h0000, 1, 0, 0);
        cyc("rs.c0",    1, 0, 1, 0, 16'h0060, 0, 1, 0);
        cyc("rs.tail",  0, 0, 0, 0, 16'h0060, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
